// File: rtl/barrel_pkg.sv
// Shared definitions for the barrel shifter / unshifter blocks.
//   state_e  : FSM encoding used by the iterative rotate stages
//   DIR_DER  : rotate right
//   DIR_IZQ  : rotate left
package barrel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    localparam logic DIR_DER = 1'b1;
    localparam logic DIR_IZQ = 1'b0;

endpackage

// File: rtl/barrel_unshifter_if.sv
// Handshake bundle for barrel_unshifter.
//   Upstream   : valid_i, ready_o, d_i, distancia_i, sentido_i
//   Downstream : valid_o, ready_i, q_o
//   Status     : busy_o
// Names are from the unshifter's point of view; the slave modport is the unshifter.
interface barrel_unshifter_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned DIST_W = $clog2(WIDTH);

    logic              valid_i;
    logic              ready_o;
    logic [WIDTH-1:0]  d_i;
    logic [DIST_W-1:0] distancia_i;
    logic              sentido_i;
    logic              valid_o;
    logic              ready_i;
    logic [WIDTH-1:0]  q_o;
    logic              busy_o;

    modport slave (
        input  valid_i,
        input  d_i,
        input  distancia_i,
        input  sentido_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output q_o,
        output busy_o
    );

    modport master (
        output valid_i,
        output d_i,
        output distancia_i,
        output sentido_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  q_o,
        input  busy_o
    );

endinterface

// File: rtl/rot1_unit.sv
// Combinational single-position rotate.
//   i_data : word to rotate
//   i_dir  : DIR_DER rotates right by one, DIR_IZQ rotates left by one
//   o_data : rotated word
module rot1_unit
    import barrel_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_data
);

    always_comb begin
        if (i_dir == DIR_DER) begin
            o_data = {i_data[0], i_data[WIDTH-1:1]};
        end else begin
            o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
        end
    end

endmodule

// File: rtl/barrel_unshifter.sv
// Iterative un-rotate: restores a word that was rotated by distancia_i positions in
// direction sentido_i, one position per clock.
//   clk_i, rst_ni : clock (rising edge), asynchronous active-low reset
//   bus (slave)   : input handshake (valid_i/ready_o, d_i, distancia_i, sentido_i),
//                   output handshake (valid_o/ready_i, q_o), busy_o status
module barrel_unshifter
    import barrel_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    barrel_unshifter_if.slave  bus
);

    localparam int unsigned DIST_W = $clog2(WIDTH);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    w_data_nxt;
    logic [DIST_W-1:0]   r_count;
    logic [DIST_W-1:0]   w_count_nxt;
    logic                r_dir;
    logic                w_dir_nxt;
    logic [WIDTH-1:0]    r_q;
    logic [WIDTH-1:0]    w_q_nxt;
    logic [WIDTH-1:0]    w_rot;

    rot1_unit #(
        .WIDTH (WIDTH)
    ) u_rot1 (
        .i_data (r_data),
        .i_dir  (r_dir),
        .o_data (w_rot)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_count <= '0;
            r_dir   <= DIR_IZQ;
            r_q     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
            r_q     <= w_q_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        w_q_nxt     = r_q;
        unique case (r_state)
            IDLE: begin
                if (bus.valid_i) begin
                    w_data_nxt  = bus.d_i;
                    w_count_nxt = bus.distancia_i;
                    // Undo by rotating the opposite way.
                    w_dir_nxt   = ~bus.sentido_i;
                    if (bus.distancia_i == '0) begin
                        w_state_nxt = DONE;
                        w_q_nxt     = bus.d_i;
                    end else begin
                        w_state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // count is >= 1 on entry, so the decrement never wraps; the zero guard
                // only covers an unreachable encoding.
                if (r_count <= DIST_W'(1)) begin
                    w_state_nxt = DONE;
                    w_data_nxt  = w_rot;
                    w_q_nxt     = w_rot;
                    w_count_nxt = '0;
                end else begin
                    w_data_nxt  = w_rot;
                    w_count_nxt = r_count - DIST_W'(1);
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // q_o is loaded only on entry to DONE, so it holds the last result through IDLE/SHIFT.
    assign bus.q_o     = r_q;
    assign bus.valid_o = (r_state == DONE);
    assign bus.ready_o = (r_state == IDLE);
    assign bus.busy_o  = (r_state != IDLE);

endmodule

// File: tb/tb_barrel_unshifter.sv
// Directed self-checking bench for barrel_unshifter (WIDTH=4).
module tb_barrel_unshifter;

    logic clk_i;
    logic rst_ni;
    int   checks;
    int   failures;
    int   n_out;

    barrel_unshifter_if #(.WIDTH(4)) bus ();

    barrel_unshifter #(
        .WIDTH (4)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference shifter: rotate d by k positions, s=1 right, s=0 left.
    function automatic logic [3:0] shift_ref(input logic [3:0] d, input int k, input logic s);
        logic [3:0] t;
        t = d;
        for (int i = 0; i < k; i++) begin
            if (s) t = {t[0], t[3:1]};
            else   t = {t[2:0], t[3]};
        end
        return t;
    endfunction

    task automatic run_word(input string tag, input logic [3:0] d, input logic [1:0] k,
                            input logic s, input logic [3:0] exp);
        int lat;
        bus.valid_i     = 1'b1;
        bus.d_i         = d;
        bus.distancia_i = k;
        bus.sentido_i   = s;
        check({tag, "_ready_before"}, 32'(bus.ready_o), 32'd1);
        tick();
        bus.valid_i = 1'b0;
        bus.d_i     = 4'hF;
        if (k != 2'd0) begin
            check({tag, "_busy_shift"}, 32'(bus.busy_o), 32'd1);
            check({tag, "_ready_shift"}, 32'(bus.ready_o), 32'd0);
        end
        lat = 0;
        while (bus.valid_o !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(k));
        check({tag, "_q"}, 32'(bus.q_o), 32'(exp));
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        check({tag, "_valid_after"}, 32'(bus.valid_o), 32'd0);
        check({tag, "_ready_after"}, 32'(bus.ready_o), 32'd1);
        check({tag, "_q_hold_idle"}, 32'(bus.q_o), 32'(exp));
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        n_out           = 0;
        rst_ni          = 1'b0;
        bus.valid_i     = 1'b0;
        bus.d_i         = '0;
        bus.distancia_i = '0;
        bus.sentido_i   = 1'b0;
        bus.ready_i     = 1'b0;
        #3;
        check("rst_q", 32'(bus.q_o), 32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        run_word("t2", 4'b0101, 2'd1, 1'b1, 4'b1010);
        run_word("t3", 4'b1001, 2'd2, 1'b1, 4'b0110);
        run_word("t4", 4'b0101, 2'd3, 1'b0, 4'b1010);

        // Asynchronous reset in the middle of SHIFT.
        bus.valid_i     = 1'b1;
        bus.d_i         = 4'b0110;
        bus.distancia_i = 2'd3;
        bus.sentido_i   = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        tick();
        check("t1_busy_before_rst", 32'(bus.busy_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t1_rst_q", 32'(bus.q_o), 32'd0);
        check("t1_rst_valid", 32'(bus.valid_o), 32'd0);
        check("t1_rst_ready", 32'(bus.ready_o), 32'd1);
        check("t1_rst_busy", 32'(bus.busy_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t1_no_valid_after_rst", 32'(bus.valid_o), 32'd0);
        run_word("t1_post", 4'b0011, 2'd1, 1'b0, 4'b1001);

        // Zero distance, then stall downstream while upstream keeps offering words.
        bus.valid_i     = 1'b1;
        bus.d_i         = 4'b1100;
        bus.distancia_i = 2'd0;
        bus.sentido_i   = 1'b1;
        tick();
        check("t5_valid", 32'(bus.valid_o), 32'd1);
        check("t5_q", 32'(bus.q_o), 32'hC);
        for (int i = 0; i < 5; i++) begin
            bus.valid_i     = i[0];
            bus.d_i         = 4'b0011;
            bus.distancia_i = 2'd1;
            tick();
            check("t5_stall_q", 32'(bus.q_o), 32'hC);
            check("t5_stall_valid", 32'(bus.valid_o), 32'd1);
            check("t5_stall_ready", 32'(bus.ready_o), 32'd0);
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        check("t5_idle_busy", 32'(bus.busy_o), 32'd0);
        tick();
        tick();
        check("t5_nothing_accepted", 32'(bus.valid_o), 32'd0);
        check("t5_q_kept", 32'(bus.q_o), 32'hC);

        // Loopback through the reference shifter with random downstream stalls.
        for (int d = 0; d < 16; d++) begin
            for (int k = 0; k < 4; k++) begin
                for (int s = 0; s < 2; s++) begin
                    int  lat;
                    int  guard;
                    logic took;
                    logic r;
                    bus.valid_i     = 1'b1;
                    bus.d_i         = shift_ref(4'(d), k, s[0]);
                    bus.distancia_i = 2'(k);
                    bus.sentido_i   = s[0];
                    tick();
                    bus.valid_i = 1'b0;
                    lat = 0;
                    while (bus.valid_o !== 1'b1 && lat < 20) begin
                        tick();
                        lat++;
                    end
                    guard = 0;
                    took  = 1'b0;
                    while (!took && guard < 50) begin
                        r = 1'($urandom_range(0, 1));
                        if (guard == 49) r = 1'b1;
                        bus.ready_i = r;
                        if (r && bus.valid_o === 1'b1) begin
                            check("t6_loop_q", 32'(bus.q_o), 32'(d));
                            n_out++;
                        end
                        tick();
                        took = r;
                        guard++;
                    end
                    bus.ready_i = 1'b0;
                end
            end
        end
        check("t6_count", 32'(n_out), 32'd128);
        check("t6_idle_end", 32'(bus.busy_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
